// File: rtl/vedic_mult_pipe_pkg.sv
// Shared constants for the pipelined Vedic multiplier.
package vedic_mult_pipe_pkg;

  // Pipeline depth from acceptance to product.
  localparam int unsigned LAT = 3;

  // Stage valid-bit indices.
  localparam int unsigned ST_S1 = 0;
  localparam int unsigned ST_S2 = 1;
  localparam int unsigned ST_S3 = 2;

  // Half-width of an operand, used for the H/L split.
  function automatic int unsigned half_w(input int unsigned w);
    return w / 2;
  endfunction

endpackage

// File: rtl/vedic_mult_pipe_core.sv
// Combinational N x N unsigned Vedic multiplier, built recursively from N/2 cores.
module vedic_core #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  generate
    if (N == 2) begin : g_base
      logic t1, t2, t3, c1;
      // 2x2 cell: partial products combined with two half-adders.
      assign t1 = a[1] & b[0];
      assign t2 = a[0] & b[1];
      assign t3 = a[1] & b[1];
      assign c1 = t1 & t2;
      assign p  = {t3 & c1, t3 ^ c1, t1 ^ t2, a[0] & b[0]};
    end else begin : g_rec
      localparam int unsigned H  = N / 2;
      localparam int unsigned PW = 2 * N;
      logic [N-1:0] hh, hl, lh, ll;
      logic [N:0]   mid;

      vedic_core #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));
      vedic_core #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
      vedic_core #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
      vedic_core #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));

      // Cross terms need one extra bit before shifting into place.
      assign mid = {1'b0, hl} + {1'b0, lh};
      assign p   = (PW'(hh) << N) + (PW'(mid) << H) + PW'(ll);
    end
  endgenerate

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined sign/magnitude Vedic multiplier with valid/ready and flush.
module vedic_mult_pipe
  import vedic_mult_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int unsigned HALF = half_w(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;

  logic [LAT-1:0]   vld;
  logic             stall, adv;
  logic             sgn, neg_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg1, neg2;
  logic [WIDTH-1:0] hh_c, hl_c, lh_c, ll_c;
  logic [WIDTH-1:0] hh, hl, lh, ll;
  logic [WIDTH:0]   mid_c;
  logic [PW-1:0]    m_c, prod_c;

  // Handshake: the whole pipe freezes only when the output is blocked.
  assign stall     = vld[ST_S3] & ~out_ready;
  assign in_ready  = ~stall;
  assign adv       = ~stall & ~flush;
  assign out_valid = vld[ST_S3];
  assign busy      = |vld;

  // S1 combinational: operand magnitudes and product sign.
  assign sgn     = in_signed & SIGNED_EN;
  assign mag_a_c = (sgn & in_a[WIDTH-1]) ? WIDTH'(-in_a) : in_a;
  assign mag_b_c = (sgn & in_b[WIDTH-1]) ? WIDTH'(-in_b) : in_b;
  assign neg_c   = sgn & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

  // S2 combinational: four half-width partial products.
  vedic_core #(.N(HALF)) u_hh (.a(mag_a[WIDTH-1:HALF]), .b(mag_b[WIDTH-1:HALF]), .p(hh_c));
  vedic_core #(.N(HALF)) u_hl (.a(mag_a[WIDTH-1:HALF]), .b(mag_b[HALF-1:0]),     .p(hl_c));
  vedic_core #(.N(HALF)) u_lh (.a(mag_a[HALF-1:0]),     .b(mag_b[WIDTH-1:HALF]), .p(lh_c));
  vedic_core #(.N(HALF)) u_ll (.a(mag_a[HALF-1:0]),     .b(mag_b[HALF-1:0]),     .p(ll_c));

  // S3 combinational: recombine and restore sign (zero magnitude stays zero).
  assign mid_c  = {1'b0, hl} + {1'b0, lh};
  assign m_c    = (PW'(hh) << WIDTH) + (PW'(mid_c) << HALF) + PW'(ll);
  assign prod_c = neg2 ? PW'(-m_c) : m_c;

  // Stage valid bits: flush wins, otherwise shift together when not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else if (!stall) begin
      vld <= {vld[ST_S2], vld[ST_S1], in_valid};
    end
  end

  // S1 data registers, loaded only for an accepted operand pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a <= '0;
      mag_b <= '0;
      neg1  <= 1'b0;
    end else if (adv && in_valid) begin
      mag_a <= mag_a_c;
      mag_b <= mag_b_c;
      neg1  <= neg_c;
    end
  end

  // S2 data registers: partial products and carried sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh   <= '0;
      hl   <= '0;
      lh   <= '0;
      ll   <= '0;
      neg2 <= 1'b0;
    end else if (adv && vld[ST_S1]) begin
      hh   <= hh_c;
      hl   <= hl_c;
      lh   <= lh_c;
      ll   <= ll_c;
      neg2 <= neg1;
    end
  end

  // S3 output register, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p <= '0;
    end else if (adv && vld[ST_S2]) begin
      out_p <= prod_c;
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench: vector table, hand sequences and randomized scoreboard.
module tb_vedic_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_signed, out_ready;
  logic [7:0]  in_a, in_b;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_p;

  logic        w_flush, w_in_valid, w_in_signed, w_out_ready;
  logic [15:0] w_in_a, w_in_b;
  logic        w_in_ready, w_out_valid, w_busy;
  logic [31:0] w_out_p;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  bit          held_prev = 1'b0;
  logic [15:0] prev_p;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          s;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  vedic_mult_pipe #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .busy(busy)
  );

  vedic_mult_pipe #(.WIDTH(16), .SIGNED_EN(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_signed(w_in_signed), .in_a(w_in_a), .in_b(w_in_b), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_p(w_out_p), .busy(w_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference product computed with plain integer arithmetic.
  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input bit s);
    longint x;
    if (s) x = longint'($signed(a)) * longint'($signed(b));
    else   x = longint'(a) * longint'(b);
    return x[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the 8-bit DUT with scoreboard and handshake/hold checks.
  task automatic cyc(input bit iv, input logic [7:0] a, input logic [7:0] b, input bit s,
                     input bit ordy, input bit fl, output bit acc);
    logic [15:0] e;
    in_valid = iv; in_a = a; in_b = b; in_signed = s; out_ready = ordy; flush = fl;
    #1;
    chk("in_ready_rule", in_ready, !(out_valid && !ordy));
    if (held_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_p", out_p, prev_p);
    end
    if (out_valid && ordy) begin
      if (q8.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = q8.pop_front();
        chk("scoreboard_p", out_p, e);
      end
    end
    acc = iv && in_ready && !fl;
    if (acc) q8.push_back(ref8(a, b, s));
    if (fl) q8.delete();
    held_prev = out_valid && !ordy && !fl;
    prev_p = out_p;
    @(posedge clk);
    #1;
  endtask

  // Single op into an empty pipe: exact 3-cycle latency with no early output.
  task automatic lat_check(input logic [7:0] a, input logic [7:0] b, input bit s,
                           input logic [15:0] exp);
    in_valid = 1; in_a = a; in_b = b; in_signed = s; out_ready = 1; flush = 0;
    #1;
    chk("lat_in_ready", in_ready, 1);
    step();
    in_valid = 0;
    for (int k = 1; k < 3; k++) begin
      chk("lat_early_valid", out_valid, 0);
      step();
    end
    chk("lat_valid", out_valid, 1);
    chk("lat_p", out_p, exp);
    step();
  endtask

  initial begin
    bit acc;
    int idx;
    logic [7:0] ba[4];
    logic [7:0] bb[4];

    vecs.push_back('{8'd15,  8'd15,  1'b0, 16'h00E1});
    vecs.push_back('{8'd255, 8'd255, 1'b0, 16'hFE01});
    vecs.push_back('{8'd1,   8'd1,   1'b0, 16'h0001});
    vecs.push_back('{8'd0,   8'd200, 1'b0, 16'h0000});
    vecs.push_back('{8'h80,  8'h80,  1'b1, 16'h4000});
    vecs.push_back('{8'hFF,  8'h7F,  1'b1, 16'hFF81});
    vecs.push_back('{8'hFF,  8'h7F,  1'b0, 16'h7E81});
    vecs.push_back('{8'h00,  8'h80,  1'b1, 16'h0000});
    vecs.push_back('{8'h80,  8'h01,  1'b1, 16'hFF80});
    vecs.push_back('{8'h7F,  8'h7F,  1'b1, 16'h3F01});
    vecs.push_back('{8'h80,  8'h7F,  1'b1, 16'hC080});

    rst_n = 0; flush = 0; in_valid = 0; in_signed = 0; in_a = 0; in_b = 0; out_ready = 1;
    w_flush = 0; w_in_valid = 0; w_in_signed = 0; w_in_a = 0; w_in_b = 0; w_out_ready = 1;
    repeat (2) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Table vectors back-to-back: vector k must appear exactly in cycle k+3.
    for (int k = 0; k < vecs.size() + 3; k++) begin
      if (k >= 3) begin
        chk("tbl_valid", out_valid, 1);
        chk("tbl_p", out_p, vecs[k-3].exp);
      end else begin
        chk("tbl_idle_valid", out_valid, 0);
      end
      if (k < vecs.size()) begin
        in_valid = 1; in_a = vecs[k].a; in_b = vecs[k].b; in_signed = vecs[k].s;
      end else begin
        in_valid = 0;
      end
      step();
    end
    chk("tbl_drained", out_valid, 0);

    lat_check(8'd15, 8'd15, 1'b0, 16'h00E1);

    // Backpressure: 4 ops with out_ready low for the first 5 cycles.
    ba = '{8'd3, 8'hFE, 8'd100, 8'h81};
    bb = '{8'd5, 8'd7,  8'd200, 8'h81};
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (idx == 4 && q8.size() == 0) break;
      if (c == 3 || c == 4) chk("bp_in_ready_low", in_ready, 0);
      cyc(idx < 4, (idx < 4) ? ba[idx] : 8'd0, (idx < 4) ? bb[idx] : 8'd0, 1'b1, c >= 5, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 4);
    chk("bp_all_emitted", q8.size(), 0);

    // Flush with three ops in flight and the output stalled.
    for (int c = 0; c < 3; c++) cyc(1'b1, 8'(c + 2), 8'd9, 1'b0, 1'b1, 1'b0, acc);
    chk("fl_busy_before", busy, 1);
    cyc(1'b1, 8'd11, 8'd11, 1'b0, 1'b0, 1'b1, acc);
    chk("fl_busy_after", busy, 0);
    chk("fl_valid_after", out_valid, 0);
    step();
    chk("fl_valid_later", out_valid, 0);
    lat_check(8'hF6, 8'd12, 1'b1, 16'hFF88);

    // Randomized traffic with flushes against the scoreboard.
    held_prev = 0;
    for (int c = 0; c < 400; c++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
          $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, acc);
    end
    for (int c = 0; c < 20 && (q8.size() != 0 || out_valid); c++)
      cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, acc);
    chk("rand_drained", q8.size(), 0);

    // Asynchronous reset in the middle of a stream.
    for (int c = 0; c < 4; c++) cyc(1'b1, 8'd200, 8'(c + 1), 1'b0, 1'b1, 1'b0, acc);
    #2;
    rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_p", out_p, 0);
    chk("arst_busy", busy, 0);
    q8.delete();
    held_prev = 0;
    in_valid = 0;
    step();
    rst_n = 1;
    step();
    chk("arst_no_partial", out_valid, 0);
    lat_check(8'd7, 8'd9, 1'b0, 16'h003F);

    // WIDTH=16 unsigned-only sweep; in_signed toggled to confirm it is ignored.
    for (int c = 0; c < 300; c++) begin
      w_in_valid  = $urandom_range(0, 3) != 0;
      w_in_a      = 16'($urandom);
      w_in_b      = 16'($urandom);
      w_in_signed = 1'($urandom);
      w_out_ready = $urandom_range(0, 3) != 0;
      if (c == 5) begin w_in_a = 16'hFFFF; w_in_b = 16'hFFFF; end
      if (c == 6) begin w_in_a = 16'h8000; w_in_b = 16'h8000; end
      #1;
      if (w_out_valid && w_out_ready) begin
        if (q16.size() == 0) chk("w16_unexpected_out", 1, 0);
        else chk("w16_p", w_out_p, q16.pop_front());
      end
      if (w_in_valid && w_in_ready) q16.push_back(32'(w_in_a) * 32'(w_in_b));
      step();
    end
    w_in_valid = 0;
    w_out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (w_out_valid) begin
        if (q16.size() == 0) chk("w16_unexpected_out", 1, 0);
        else chk("w16_p", w_out_p, q16.pop_front());
      end
      step();
    end
    chk("w16_drained", q16.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
